// File: rtl/instr_mem_fetch.sv
// Instruction memory with a program-load port and a one-entry registered fetch response.
// Latency is 1 cycle; req_ready drops during load, flush or reset, and while a held response is not accepted.
`timescale 1ns/1ps
module instr_mem_fetch #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [DATA_W-1:0] FAULT_INSTR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic [1:0]               rsp_fault,
  output logic [ADDR_W-1:0]        rsp_addr,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     flush,
  output logic [31:0]              fetch_count
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word;
  logic              misaligned;
  logic              out_of_range;
  logic              accept;
  logic              retire;

  assign offset       = req_addr - BASE_ADDR;
  assign word         = offset >> 2;
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = (req_addr < BASE_ADDR) || (word >= ADDR_W'(DEPTH));

  assign req_ready = rst_n & ~load_en & ~flush & (~rsp_valid | rsp_ready);
  assign accept    = req_valid & req_ready;
  assign retire    = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (rst_n && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Faulting fetches never touch the array; misalignment wins over range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_instr <= FAULT_INSTR;
      rsp_fault <= FAULT_NONE;
      rsp_addr  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= req_addr;
      if (misaligned) begin
        rsp_instr <= FAULT_INSTR;
        rsp_fault <= FAULT_MISALIGN;
      end else if (out_of_range) begin
        rsp_instr <= FAULT_INSTR;
        rsp_fault <= FAULT_RANGE;
      end else begin
        rsp_instr <= mem[word[IDX_W-1:0]];
        rsp_fault <= FAULT_NONE;
      end
    end else if (flush || retire) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (retire && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: u_a at BASE_ADDR 0, u_b at BASE_ADDR 0x00400000, sharing all inputs.
`timescale 1ns/1ps
module tb_instr_mem_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  fault;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, rsp_ready, load_en, flush;
  logic [31:0] req_addr, load_data;
  logic [9:0]  load_addr;

  logic        req_ready_o   [2];
  logic        rsp_valid_o   [2];
  logic [31:0] rsp_instr_o   [2];
  logic [1:0]  rsp_fault_o   [2];
  logic [31:0] rsp_addr_o    [2];
  logic [31:0] fetch_count_o [2];

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  exp_t        last   [2];
  logic [31:0] exp_cnt[2] = '{32'd0, 32'd0};
  logic        pend   [2] = '{1'b0, 1'b0};
  logic        held   [2] = '{1'b0, 1'b0};
  logic        rstd   [2] = '{1'b1, 1'b1};
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  instr_mem_fetch u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_o[0]), .req_addr(req_addr),
    .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_o[0]),
    .rsp_fault(rsp_fault_o[0]), .rsp_addr(rsp_addr_o[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .flush(flush), .fetch_count(fetch_count_o[0])
  );

  instr_mem_fetch #(.BASE_ADDR(32'h0040_0000)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_o[1]), .req_addr(req_addr),
    .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_o[1]),
    .rsp_fault(rsp_fault_o[1]), .rsp_addr(rsp_addr_o[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .flush(flush), .fetch_count(fetch_count_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  // Samples 1 time unit before each rising edge, when inputs and outputs are settled.
  always begin : monitor
    exp_t e;
    logic acc, ret, got;
    @(negedge clk);
    #4;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d req_ready", d), 32'(req_ready_o[d]),
          32'(rst_n & ~load_en & ~flush & (~rsp_valid_o[d] | rsp_ready)));
      if (pend[d]) begin
        got = 1'b0;
        if (d == 0 && exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          got = 1'b1;
        end else if (d == 1 && exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          got = 1'b1;
        end
        n_vec++;
        if (!got) begin
          n_err++;
          $display("FAIL u%0d unexpected response: got addr %08h, required no response", d, rsp_addr_o[d]);
        end else begin
          last[d] = e;
        end
      end
      if (pend[d] || held[d]) begin
        chk($sformatf("u%0d rsp_valid", d), 32'(rsp_valid_o[d]), 32'd1);
        chk($sformatf("u%0d rsp_instr", d), rsp_instr_o[d], last[d].instr);
        chk($sformatf("u%0d rsp_fault", d), 32'(rsp_fault_o[d]), 32'(last[d].fault));
        chk($sformatf("u%0d rsp_addr", d), rsp_addr_o[d], last[d].addr);
      end else begin
        chk($sformatf("u%0d rsp_valid idle", d), 32'(rsp_valid_o[d]), 32'd0);
      end
      if (rstd[d]) begin
        chk($sformatf("u%0d reset rsp_instr", d), rsp_instr_o[d], 32'd0);
        chk($sformatf("u%0d reset rsp_fault", d), 32'(rsp_fault_o[d]), 32'd0);
        chk($sformatf("u%0d reset rsp_addr", d), rsp_addr_o[d], 32'd0);
      end
      chk($sformatf("u%0d fetch_count", d), fetch_count_o[d], exp_cnt[d]);
      acc     = req_valid & req_ready_o[d];
      ret     = rsp_valid_o[d] & rsp_ready;
      pend[d] = acc;
      held[d] = rst_n & rsp_valid_o[d] & ~rsp_ready & ~flush & ~acc;
      rstd[d] = ~rst_n;
      if (!rst_n) exp_cnt[d] = 32'd0;
      else if (ret && exp_cnt[d] != 32'hFFFF_FFFF) exp_cnt[d] = exp_cnt[d] + 32'd1;
    end
  end

  task automatic load(input logic [9:0] a, input logic [31:0] v);
    load_en = 1'b1; load_addr = a; load_data = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Expected responses for u_a and u_b are pushed as the request is issued.
  task automatic fetch(input logic [31:0] a, input logic [31:0] i0, input logic [1:0] f0,
                       input logic [31:0] i1, input logic [1:0] f1);
    logic done;
    exp_q0.push_back(exp_t'{i0, f0, a});
    exp_q1.push_back(exp_t'{i1, f1, a});
    req_valid = 1'b1;
    req_addr  = a;
    done      = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #4;
      done = req_ready_o[0];
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL fetch %08h accept: req_ready stayed 0, required 1", a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load(10'd0, 32'h2001_000A);
    load(10'd1, 32'h2002_0014);
    load(10'd2, 32'h0022_1820);

    fetch(32'h0, 32'h2001_000A, 2'b00, 32'h0, 2'b10);
    fetch(32'h4, 32'h2002_0014, 2'b00, 32'h0, 2'b10);
    fetch(32'h8, 32'h0022_1820, 2'b00, 32'h0, 2'b10);
    @(negedge clk);
    #4 chk("count after three fetches", fetch_count_o[0], 32'd3);
    @(negedge clk);

    // Faults and the relocated instance's address window.
    fetch(32'h6,         32'h0, 2'b01, 32'h0,         2'b01);
    fetch(32'h1000,      32'h0, 2'b10, 32'h0,         2'b10);
    fetch(32'h0040_0000, 32'h0, 2'b10, 32'h2001_000A, 2'b00);
    fetch(32'h003F_FFFC, 32'h0, 2'b10, 32'h0,         2'b10);
    repeat (2) @(negedge clk);

    // Held response survives a load to the same word.
    rsp_ready = 1'b0;
    fetch(32'h4, 32'h2002_0014, 2'b00, 32'h0, 2'b10);
    for (int c = 1; c <= 5; c++) begin
      load_en = (c == 2); load_addr = 10'd1; load_data = 32'hDEAD_BEEF;
      #4;
      chk("hold req_ready", 32'(req_ready_o[0]), 32'd0);
      chk("hold rsp_instr", rsp_instr_o[0], 32'h2002_0014);
      @(negedge clk);
    end
    load_en = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    fetch(32'h4, 32'hDEAD_BEEF, 2'b00, 32'h0, 2'b10);

    // Load blocks a simultaneous request but still writes.
    load_en = 1'b1; load_addr = 10'd2; load_data = 32'h1111_1111;
    req_valid = 1'b1; req_addr = 32'h8;
    #4 chk("load blocks req_ready", 32'(req_ready_o[0]), 32'd0);
    @(negedge clk);
    load_en = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    fetch(32'h8, 32'h1111_1111, 2'b00, 32'h0, 2'b10);

    // Flush of a held response: dropped, not counted.
    rsp_ready = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #4 chk("flush req_ready", 32'(req_ready_o[0]), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #4 chk("count after flush", fetch_count_o[0], 32'd9);
    @(negedge clk);

    // Flush while the response is being accepted still counts it.
    rsp_ready = 1'b1;
    fetch(32'h0, 32'h2001_000A, 2'b00, 32'h0, 2'b10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #4 chk("count flush with ready", fetch_count_o[0], 32'd10);
    @(negedge clk);

    // Reset with a pending response and a request present.
    rsp_ready = 1'b0;
    fetch(32'h4, 32'hDEAD_BEEF, 2'b00, 32'h0, 2'b10);
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;
    #4;
    chk("reset rsp_valid", 32'(rsp_valid_o[0]), 32'd0);
    chk("reset fetch_count", fetch_count_o[0], 32'd0);
    @(negedge clk);

    // Saturation of the counter.
    rsp_ready = 1'b1;
    force u_a.fetch_count = 32'hFFFF_FFFE;
    exp_cnt[0] = 32'hFFFF_FFFE;
    #1 release u_a.fetch_count;
    @(negedge clk);
    fetch(32'h0, 32'h2001_000A, 2'b00, 32'h0, 2'b10);
    fetch(32'h4, 32'hDEAD_BEEF, 2'b00, 32'h0, 2'b10);
    @(negedge clk);
    #4;
    chk("count saturated", fetch_count_o[0], 32'hFFFF_FFFF);
    chk("u1 count", fetch_count_o[1], 32'd2);
    @(negedge clk);
    #4;
    chk("u0 queue drained", 32'(exp_q0.size()), 32'd0);
    chk("u1 queue drained", 32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised instruction memory with a synchronous read port, a valid/ready fetch handshake and a one-entry output register.
- Adds a program-load write port, address fault detection, a flush input and a fetched-instruction counter.
- Sits between the PC/fetch stage and decode in the pipelined core generation; replaces the fixed, combinationally read program ROM.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 32, byte-address width of fetch requests
DEPTH, 1024, number of DATA_W words; power of two, minimum 2
BASE_ADDR, 32'h00000000, byte address of word 0; word-aligned
FAULT_INSTR, 32'h00000000, value driven on rsp_instr for faulting responses (NOP)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  fetch request present
req_ready  out  1  block accepts the request this cycle
req_addr  in  ADDR_W  fetch byte address
rsp_valid  out  1  response register holds a valid response
rsp_ready  in  1  consumer accepts the response this cycle
rsp_instr  out  DATA_W  fetched instruction
rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range; 11 never driven
rsp_addr  out  ADDR_W  byte address belonging to the response
load_en  in  1  write load_data into memory this cycle
load_addr  in  $clog2(DEPTH)  word index for the load write
load_data  in  DATA_W  word to write
flush  in  1  discard the held response; accept no request this cycle
fetch_count  out  32  accepted-response counter, saturates at 32'hFFFFFFFF

Behaviour:
- Reset (rst_n=0 at a clock edge): rsp_valid=0, rsp_instr=FAULT_INSTR, rsp_fault=00, rsp_addr=0, fetch_count=0. Memory contents are not reset and are undefined until loaded. Reset overrides flush, load and fetch in the same cycle; a load is not performed during reset.
- req_ready = rst_n & !load_en & !flush & (!rsp_valid | rsp_ready). This is combinational; req_ready does not depend on req_valid.
- A fetch is accepted on an edge where req_valid & req_ready. On the next cycle: rsp_valid=1, rsp_addr=req_addr, and rsp_instr/rsp_fault are set from the fault check below. Latency is exactly 1 cycle. Back-to-back fetches give one response per cycle while rsp_ready=1.
- Fault check, evaluated at acceptance:
  - misaligned if req_addr[1:0]!=0; this has priority.
  - out of range if req_addr<BASE_ADDR or ((req_addr-BASE_ADDR)>>2)>=DEPTH.
  - Any fault: rsp_instr=FAULT_INSTR and the memory is not read.
  - No fault: rsp_instr=mem[(req_addr-BASE_ADDR)>>2]. The subtraction is done at ADDR_W width.
- Hold: while rsp_valid & !rsp_ready, rsp_instr, rsp_fault and rsp_addr stay stable. A later load to the same word does not change the held response.
- Response retire: rsp_valid&rsp_ready with no new acceptance sets rsp_valid=0 next cycle. Retire and accept in the same cycle replaces the response; rsp_valid stays 1.
- fetch_count increments by 1 on each rsp_valid&rsp_ready edge, faulting responses included, and saturates at the maximum.
- Load: on an edge with load_en=1 and rst_n=1, mem[load_addr]<=load_data.
  - No fetch is accepted in that cycle.
  - The held response is unaffected.
  - A fetch of that word in a later cycle returns the new data.
- Flush: on an edge with flush=1, rsp_valid<=0 and no fetch is accepted. A response with rsp_ready=1 in the flush cycle is still counted. Flush and load together: both take effect.
- Reset mid-operation: a pending response is dropped, and a request presented during reset is neither accepted nor answered.

Test Plan:
- Load 0x2001000A/0x20020014/0x00221820 into words 0-2, then fetch 0x0,0x4,0x8 with rsp_ready=1 -> responses on consecutive cycles, each 1 cycle after its request, fault=00, fetch_count=3.
- Fetch 0x6 -> rsp_fault=01, rsp_instr=0x00000000, rsp_addr=0x6. Fetch 0x1000 (DEPTH=1024) -> rsp_fault=10.
- Fetch 0x4 with rsp_ready=0 for 5 cycles, with load of word 1 = 0xDEADBEEF in cycle 2 -> rsp_instr held at 0x20020014 and req_ready=0 throughout. After retire, refetch 0x4 -> 0xDEADBEEF.
- Assert load_en and req_valid together -> req_ready=0, no response next cycle, write performed.
- Hold a valid response, assert flush -> rsp_valid=0 next cycle, fetch_count unchanged. Assert rst_n=0 with rsp_valid=1 -> all outputs at reset values next cycle.
- With BASE_ADDR=0x00400000, fetch 0x003FFFFC -> fault 10. Fetch 0x00400000 -> word 0. Force fetch_count to 0xFFFFFFFF by preset or long run, then one more handshake -> stays 0xFFFFFFFF.
